// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | time_set_ctrl_pkg : shared limits, FSM encoding, BCD increment     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package time_set_ctrl_pkg;

  localparam logic [7:0] c_HR_MAX  = 8'h23;
  localparam logic [7:0] c_MIN_MAX = 8'h59;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_HR  = 2'd1,
    EDIT_MIN = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  // Out-of-range or malformed BCD collapses to zero rather than propagating.
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] w_res;
    if ((v == max_v) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v > max_v))
      w_res = 8'h00;
    else if (v[3:0] == 4'd9)
      w_res = {v[7:4] + 4'd1, 4'h0};
    else
      w_res = {v[7:4], v[3:0] + 4'd1};
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_debounce : 2-FF sync + stability counter, one pulse per press  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module key_debounce #(
  parameter int DB_W = 20
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;
  logic            w_diff;
  logic            w_flip;

  assign w_diff = (r_sync2 != r_level);
  assign w_flip = w_diff && (r_cnt == {DB_W{1'b1}});

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= w_flip && !r_sync2;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | time_set_ctrl : pushbutton time entry driving the clock load port  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int         DB_W    = 20,
  parameter logic [7:0] HR_MAX  = c_HR_MAX,
  parameter logic [7:0] MIN_MAX = c_MIN_MAX
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       mode_n,
  input  logic       next_n,
  input  logic       inc_n,
  input  logic [7:0] cur_hr,
  input  logic [7:0] cur_min,
  output logic [7:0] set_hr,
  output logic [7:0] set_min,
  output logic       load,
  output logic       editing,
  output logic       sel_min
);

  logic       w_mode;
  logic       w_next;
  logic       w_inc;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_cap;
  logic       w_inc_hr;
  logic       w_inc_min;
  logic [7:0] r_set_hr;
  logic [7:0] r_set_min;
  logic       r_load;

  key_debounce #(.DB_W(DB_W)) u_db_mode (.Clock(Clock), .Resetn(Resetn), .key_n(mode_n), .press(w_mode));
  key_debounce #(.DB_W(DB_W)) u_db_next (.Clock(Clock), .Resetn(Resetn), .key_n(next_n), .press(w_next));
  key_debounce #(.DB_W(DB_W)) u_db_inc  (.Clock(Clock), .Resetn(Resetn), .key_n(inc_n),  .press(w_inc));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= (w_state_nxt == COMMIT);
    end
  end

  // Priority mode > next > inc: lower-priority events in the same cycle are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_inc_hr    = 1'b0;
    w_inc_min   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mode) begin
          w_state_nxt = EDIT_HR;
          w_cap       = 1'b1;
        end
      end
      EDIT_HR: begin
        if (w_mode)      w_state_nxt = COMMIT;
        else if (w_next) w_state_nxt = EDIT_MIN;
        else if (w_inc)  w_inc_hr    = 1'b1;
      end
      EDIT_MIN: begin
        if (w_mode)      w_state_nxt = COMMIT;
        else if (w_next) w_state_nxt = EDIT_HR;
        else if (w_inc)  w_inc_min   = 1'b1;
      end
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_set_hr  <= 8'h00;
      r_set_min <= 8'h00;
    end else if (w_cap) begin
      r_set_hr  <= cur_hr;
      r_set_min <= cur_min;
    end else begin
      if (w_inc_hr)  r_set_hr  <= inc_bcd(r_set_hr, HR_MAX);
      if (w_inc_min) r_set_min <= inc_bcd(r_set_min, MIN_MAX);
    end
  end

  assign set_hr  = r_set_hr;
  assign set_min = r_set_min;
  assign load    = r_load;
  assign editing = (r_state == EDIT_HR) || (r_state == EDIT_MIN);
  assign sel_min = (r_state == EDIT_MIN);

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_time_set_ctrl : randomized scoreboard bench for time_set_ctrl   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_time_set_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       mode_n, next_n, inc_n;
  logic [7:0] cur_hr, cur_min;
  logic [7:0] set_hr, set_min;
  logic       load, editing, sel_min;

  int checks   = 0;
  int failures = 0;

  // Output snapshot: {editing, sel_min, set_hr, set_min, load}
  logic [18:0] exp_q[$];
  logic [18:0] prev_t = '0;

  // Reference model state
  bit         m_edit = 0;
  bit         m_sel  = 0;
  logic [7:0] m_hr   = 8'h00;
  logic [7:0] m_mn   = 8'h00;

  time_set_ctrl #(.DB_W(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .mode_n(mode_n), .next_n(next_n), .inc_n(inc_n),
    .cur_hr(cur_hr), .cur_min(cur_min), .set_hr(set_hr), .set_min(set_min),
    .load(load), .editing(editing), .sel_min(sel_min)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_inc(input logic [7:0] v, input int maxd);
    int hi, lo, d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 8'h00;
    d = hi * 10 + lo;
    if (d >= maxd) return 8'h00;
    d = d + 1;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic logic [18:0] snap(input bit ld);
    return {m_edit, m_sel, m_hr, m_mn, ld};
  endfunction

  // m = {mode, next, inc}; only the highest-priority key acts.
  task automatic model_apply(input logic [2:0] m);
    if (m[2]) begin
      if (!m_edit) begin
        m_hr = cur_hr; m_mn = cur_min; m_edit = 1; m_sel = 0;
        exp_q.push_back(snap(0));
      end else begin
        m_edit = 0; m_sel = 0;
        exp_q.push_back(snap(1));
        exp_q.push_back(snap(0));
      end
    end else if (m[1]) begin
      if (m_edit) begin
        m_sel = ~m_sel;
        exp_q.push_back(snap(0));
      end
    end else if (m[0]) begin
      if (m_edit) begin
        if (m_sel) m_mn = m_inc(m_mn, 59);
        else       m_hr = m_inc(m_hr, 23);
        exp_q.push_back(snap(0));
      end
    end
  endtask

  task automatic drive_keys(input logic [2:0] m, input int hold);
    @(posedge Clock); #1;
    mode_n = ~m[2]; next_n = ~m[1]; inc_n = ~m[0];
    repeat (hold) @(posedge Clock);
    #1;
    mode_n = 1'b1; next_n = 1'b1; inc_n = 1'b1;
    repeat (10) @(posedge Clock);
  endtask

  task automatic press(input logic [2:0] m);
    model_apply(m);
    drive_keys(m, $urandom_range(8, 14));
  endtask

  // Monitor: every change of the visible output tuple must match the next expected snapshot.
  always @(negedge Clock) begin
    logic [18:0] cur_t;
    logic [18:0] e;
    cur_t = {editing, sel_min, set_hr, set_min, load};
    if (cur_t !== prev_t) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_change", 32'(cur_t), 32'(prev_t));
      end else begin
        e = exp_q.pop_front();
        chk("output_tuple", 32'(cur_t), 32'(e));
      end
      prev_t = cur_t;
    end
  end

  initial begin
    Resetn = 1'b0; mode_n = 1'b1; next_n = 1'b1; inc_n = 1'b1;
    cur_hr = 8'h00; cur_min = 8'h00;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_set_hr", 32'(set_hr), 32'h00);
    chk("rst_set_min", 32'(set_min), 32'h00);
    chk("rst_load", 32'(load), 32'h0);
    chk("rst_editing", 32'(editing), 32'h0);
    chk("rst_sel_min", 32'(sel_min), 32'h0);
    Resetn = 1'b1;
    repeat (3) @(posedge Clock);

    // Short bounce: no event expected
    drive_keys(3'b100, 2);
    chk("bounce_editing", 32'(editing), 32'h0);

    // Held mode key: event latency and single event while held
    cur_hr = 8'h14; cur_min = 8'h37;
    model_apply(3'b100);
    @(posedge Clock); #1;
    mode_n = 1'b0;
    repeat (6) @(posedge Clock);
    #1 chk("latency_before", 32'(editing), 32'h0);
    @(posedge Clock);
    #1 chk("latency_after", 32'(editing), 32'h1);
    chk("capture_hr", 32'(set_hr), 32'h14);
    chk("capture_min", 32'(set_min), 32'h37);
    repeat (25) @(posedge Clock);
    #1 mode_n = 1'b1;
    repeat (10) @(posedge Clock);
    press(3'b100);

    // Hour/minute wrap
    cur_hr = 8'h22; cur_min = 8'h59;
    press(3'b100);
    press(3'b001);
    press(3'b001);
    press(3'b010);
    press(3'b001);
    press(3'b100);

    // Malformed captured hour
    cur_hr = 8'h3A; cur_min = 8'h00;
    press(3'b100);
    press(3'b001);
    chk("invalid_hr_wrap", 32'(set_hr), 32'h00);
    press(3'b100);

    // Commit of 09:05 then ignored keys in IDLE
    cur_hr = 8'h09; cur_min = 8'h05;
    press(3'b100);
    press(3'b010);
    press(3'b100);
    chk("commit_hr", 32'(set_hr), 32'h09);
    chk("commit_min", 32'(set_min), 32'h05);
    press(3'b010);
    press(3'b001);

    // Simultaneous presses
    cur_hr = 8'h11; cur_min = 8'h22;
    press(3'b100);
    press(3'b101);
    press(3'b100);
    press(3'b011);
    press(3'b001);

    // Asynchronous reset mid-edit
    exp_q.push_back(19'h0);
    m_edit = 0; m_sel = 0; m_hr = 8'h00; m_mn = 8'h00;
    @(posedge Clock); #3;
    Resetn = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({editing, sel_min, set_hr, set_min, load}), 32'h0);
    @(posedge Clock); #1;
    Resetn = 1'b1;
    repeat (20) @(posedge Clock);

    // Randomized sequence
    for (int i = 0; i < 60; i++) begin
      logic [2:0] m;
      if ($urandom_range(0, 5) == 0) begin
        cur_hr  = 8'($urandom_range(0, 255));
        cur_min = 8'($urandom_range(0, 255));
      end else begin
        cur_hr  = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
        cur_min = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      end
      m = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 4) == 0) drive_keys(m, $urandom_range(1, 3));
      else                           press(m);
    end

    repeat (10) @(posedge Clock);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
